// File: rtl/flappy_pkg.sv
// Shared constants, column type and spawn-column helper for the pipe field generator.
package flappy_pkg;

  localparam int DEF_ROWS    = 16;
  localparam int DEF_COLS    = 16;
  localparam int MAX_ROWS    = 64;
  localparam int LFSR_W      = 10;
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 6;

  typedef logic [DEF_ROWS-1:0] col_t;
  typedef logic [MAX_ROWS-1:0] wide_col_t;

  // Wide so any matrix height up to MAX_ROWS can size-cast the result down.
  function automatic wide_col_t gap_mask(input int g, input int gap = 4,
                                         input int rows = DEF_ROWS);
    wide_col_t m;
    m = '0;
    for (int r = 0; r < MAX_ROWS; r++) begin
      m[r] = (r < rows) && !((r >= g) && (r < g + gap));
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_field_gen_if.sv
// Controller/matrix-facing bundle of the pipe field generator.
interface pipe_field_gen_if
  import flappy_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int SCORE_W = 8
);
  localparam int RW = $clog2(ROWS);

  logic                       enable;
  logic [RW-1:0]              bird_row;
  logic [ROWS-1:0][COLS-1:0]  GrnPixels;
  logic                       tick;
  logic                       collide;
  logic [SCORE_W-1:0]         score;

  modport master (
    output enable, bird_row,
    input  GrnPixels, tick, collide, score
  );

  modport slave (
    input  enable, bird_row,
    output GrnPixels, tick, collide, score
  );

endinterface

// File: rtl/gap_lfsr.sv
// 10-bit Fibonacci LFSR (x^10 + x^7 + 1) that picks pipe gap positions.
module gap_lfsr
  import flappy_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 10'h1A5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  // An all-zero state would lock up, so a zero seed is forced to 1.
  localparam logic [LFSR_W-1:0] SEED = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (advance) begin
      state <= {state[LFSR_W-2:0], state[LFSR_TAP_HI] ^ state[LFSR_TAP_LO]};
    end
  end

endmodule

// File: rtl/pipe_field_gen.sv
// Scrolling pipe field: spawns gapped pipe columns, scrolls them, tracks collision and score.
module pipe_field_gen
  import flappy_pkg::*;
#(
  parameter int                ROWS      = DEF_ROWS,
  parameter int                COLS      = DEF_COLS,
  parameter int                GAP       = 4,
  parameter int                TICK_DIV  = 8,
  parameter int                SPACING   = 6,
  parameter int                BIRD_COL  = 3,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 10'h1A5,
  parameter int                SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  pipe_field_gen_if.slave    bus
);

  localparam int RW    = $clog2(ROWS);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SP_W  = $clog2(SPACING + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SP_W-1:0]  SP_LOAD  = SP_W'(SPACING - 1);

  logic [DIV_W-1:0]  div;
  logic [SP_W-1:0]   sp;
  logic [LFSR_W-1:0] lfsr_state;
  logic              overlap;
  logic              run;
  logic              tick_next;
  logic [ROWS-1:0]   spawn_col;
  logic [ROWS-1:0]   bird_col_bits;
  int                v;
  int                g;

  gap_lfsr #(
    .LFSR_SEED (LFSR_SEED)
  ) u_gap_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (tick_next),
    .state   (lfsr_state)
  );

  always_comb begin
    overlap   = bus.GrnPixels[bus.bird_row][BIRD_COL];
    // A hit stalls the field in the same cycle, so a colliding pipe never scores.
    run       = bus.enable && !bus.collide && !overlap;
    tick_next = run && (div == DIV_LAST);

    // Low RW bits of the LFSR, folded back into the legal range 0..ROWS-GAP.
    v = int'(lfsr_state) % (1 << RW);
    g = (v <= ROWS - GAP) ? v : v - (ROWS - GAP + 1);

    spawn_col = (sp == '0) ? ROWS'(gap_mask(g, GAP, ROWS)) : '0;

    bird_col_bits = '0;
    for (int r = 0; r < ROWS; r++) begin
      bird_col_bits[r] = bus.GrnPixels[r][BIRD_COL];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.GrnPixels <= '0;
      bus.tick      <= 1'b0;
      bus.collide   <= 1'b0;
      bus.score     <= '0;
      div           <= '0;
      sp            <= '0;
    end else begin
      bus.tick <= tick_next;

      if (bus.enable && overlap) begin
        bus.collide <= 1'b1;
      end

      if (run) begin
        div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      end

      // Scroll step: shift toward column 0, new column enters at COLS-1.
      if (tick_next) begin
        for (int r = 0; r < ROWS; r++) begin
          bus.GrnPixels[r] <= {spawn_col[r], bus.GrnPixels[r][COLS-1:1]};
        end
        sp <= (sp == '0) ? SP_LOAD : sp - SP_W'(1);
        if ((|bird_col_bits) && (bus.score != '1)) begin
          bus.score <= bus.score + SCORE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_field_gen.sv
// Directed bench for pipe_field_gen: reset, scroll/spawn, scoring, collision, enable hold, saturation.
module tb_pipe_field_gen;
  import flappy_pkg::*;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  typedef logic [ROWS-1:0][COLS-1:0] field_t;

  logic clk = 1'b0;
  logic reset;
  logic reset6;

  always #5 clk = ~clk;

  pipe_field_gen_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(8)) bus ();
  pipe_field_gen_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(2)) bus6 ();

  pipe_field_gen #(
    .ROWS(ROWS), .COLS(COLS), .GAP(4), .TICK_DIV(2), .SPACING(4),
    .BIRD_COL(3), .LFSR_SEED(10'h1A5), .SCORE_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipe_field_gen #(
    .ROWS(ROWS), .COLS(COLS), .GAP(4), .TICK_DIV(2), .SPACING(4),
    .BIRD_COL(3), .LFSR_SEED(10'h1A5), .SCORE_W(2)
  ) dut6 (
    .clk   (clk),
    .reset (reset6),
    .bus   (bus6)
  );

  int checks   = 0;
  int failures = 0;

  function automatic col_t col_of(input field_t f, input int c);
    col_t res;
    for (int r = 0; r < ROWS; r++) res[r] = f[r][c];
    return res;
  endfunction

  function automatic field_t with_col(input field_t f, input int c, input col_t v);
    field_t res;
    res = f;
    for (int r = 0; r < ROWS; r++) res[r][c] = v[r];
    return res;
  endfunction

  // First gap row of pipe k (spawned after 4k LFSR steps), used to steer the bird.
  function automatic int gap_of(input int k);
    logic [9:0] l;
    int         vv;
    l = 10'h1A5;
    for (int i = 0; i < 4 * k; i++) l = {l[8:0], l[9] ^ l[6]};
    vv = int'(l[3:0]);
    return (vv <= 12) ? vv : vv - 13;
  endfunction

  // Hand-derived field after 13 ticks: pipes 0..3 at columns 3,7,11,15.
  function automatic field_t field_after_13();
    field_t f;
    f = '0;
    f = with_col(f, 3,  16'hFE1F);
    f = with_col(f, 7,  16'hFFC3);
    f = with_col(f, 11, 16'hFF87);
    f = with_col(f, 15, 16'hFFF0);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int c;
      c = 0;
      do begin
        step();
        c++;
      end while (!bus.tick && c < 8);
      if (!bus.tick) begin
        checks++;
        failures++;
        $display("FAIL tick_timeout got=no tick after %0d cycles exp=tick (tick %0d of %0d)", c, i + 1, n);
        return;
      end
    end
  endtask

  task automatic test_reset();
    field_t e;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.bird_row = 4'd6;
    repeat (3) step();
    checks++; if (bus.GrnPixels !== '0) begin failures++; $display("FAIL rst_field got=%h exp=0", bus.GrnPixels); end
    checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL rst_tick got=%b exp=0", bus.tick); end
    checks++; if (bus.collide !== 1'b0) begin failures++; $display("FAIL rst_collide got=%b exp=0", bus.collide); end
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL rst_score got=%0d exp=0", bus.score); end
    reset = 1'b0;
    bus.enable = 1'b1;
    step();
    checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL first_cycle_tick got=%b exp=0", bus.tick); end
    step();
    checks++; if (bus.tick !== 1'b1) begin failures++; $display("FAIL second_cycle_tick got=%b exp=1", bus.tick); end
    e = with_col('0, 15, 16'hFE1F);
    checks++; if (bus.GrnPixels !== e) begin failures++; $display("FAIL first_spawn got=%h exp=%h", bus.GrnPixels, e); end
    step();
    checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL tick_one_cycle got=%b exp=0", bus.tick); end
  endtask

  task automatic test_scroll_score();
    field_t e;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.bird_row = 4'd6;
    bus.enable = 1'b1;
    run_ticks(13);
    e = field_after_13();
    checks++; if (bus.GrnPixels !== e) begin failures++; $display("FAIL field_t13 got=%h exp=%h", bus.GrnPixels, e); end
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL score_t13 got=%0d exp=0", bus.score); end
    run_ticks(1);
    checks++; if (bus.score !== 8'd1) begin failures++; $display("FAIL score_t14 got=%0d exp=1", bus.score); end
    checks++; if (col_of(bus.GrnPixels, 2) !== 16'hFE1F) begin failures++; $display("FAIL col2_t14 got=%h exp=fe1f", col_of(bus.GrnPixels, 2)); end
    checks++; if (col_of(bus.GrnPixels, 14) !== 16'hFFF0) begin failures++; $display("FAIL col14_t14 got=%h exp=fff0", col_of(bus.GrnPixels, 14)); end
    checks++; if (col_of(bus.GrnPixels, 15) !== 16'h0000) begin failures++; $display("FAIL col15_t14 got=%h exp=0", col_of(bus.GrnPixels, 15)); end
    checks++; if (bus.collide !== 1'b0) begin failures++; $display("FAIL collide_t14 got=%b exp=0", bus.collide); end
  endtask

  task automatic test_collide();
    field_t e;
    int     seen;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.bird_row = 4'd0;
    bus.enable = 1'b1;
    run_ticks(13);
    checks++; if (bus.collide !== 1'b0) begin failures++; $display("FAIL collide_early got=%b exp=0", bus.collide); end
    step();
    checks++; if (bus.collide !== 1'b1) begin failures++; $display("FAIL collide_set got=%b exp=1", bus.collide); end
    checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL collide_tick got=%b exp=0", bus.tick); end
    e = field_after_13();
    checks++; if (bus.GrnPixels !== e) begin failures++; $display("FAIL collide_field got=%h exp=%h", bus.GrnPixels, e); end
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL collide_score got=%0d exp=0", bus.score); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.tick) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL frozen_ticks got=%0d exp=0", seen); end
    checks++; if (bus.GrnPixels !== e) begin failures++; $display("FAIL frozen_field got=%h exp=%h", bus.GrnPixels, e); end
    checks++; if (bus.collide !== 1'b1) begin failures++; $display("FAIL collide_sticky got=%b exp=1", bus.collide); end
  endtask

  task automatic test_reset_after_collide();
    field_t e;
    reset = 1'b1;
    bus.bird_row = 4'd6;
    bus.enable = 1'b1;
    step();
    checks++; if (bus.GrnPixels !== '0) begin failures++; $display("FAIL rst2_field got=%h exp=0", bus.GrnPixels); end
    checks++; if (bus.collide !== 1'b0) begin failures++; $display("FAIL rst2_collide got=%b exp=0", bus.collide); end
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL rst2_score got=%0d exp=0", bus.score); end
    reset = 1'b0;
    step();
    checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL rst2_first_tick got=%b exp=0", bus.tick); end
    step();
    checks++; if (bus.tick !== 1'b1) begin failures++; $display("FAIL rst2_second_tick got=%b exp=1", bus.tick); end
    e = with_col('0, 15, 16'hFE1F);
    checks++; if (bus.GrnPixels !== e) begin failures++; $display("FAIL rst2_spawn got=%h exp=%h", bus.GrnPixels, e); end
  endtask

  task automatic test_enable_hold();
    field_t e;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.bird_row = 4'd6;
    bus.enable = 1'b1;
    step();
    step();
    step();
    // Divider now sits at 1 with one tick already taken.
    bus.enable = 1'b0;
    e = with_col('0, 15, 16'hFE1F);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL hold_tick cyc=%0d got=%b exp=0", i, bus.tick); end
      checks++; if (bus.GrnPixels !== e) begin failures++; $display("FAIL hold_field cyc=%0d got=%h exp=%h", i, bus.GrnPixels, e); end
    end
    bus.enable = 1'b1;
    step();
    checks++; if (bus.tick !== 1'b1) begin failures++; $display("FAIL resume_tick got=%b exp=1", bus.tick); end
    e = with_col('0, 14, 16'hFE1F);
    checks++; if (bus.GrnPixels !== e) begin failures++; $display("FAIL resume_field got=%h exp=%h", bus.GrnPixels, e); end
    step();
    checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL resume_gap got=%b exp=0", bus.tick); end
    step();
    checks++; if (bus.tick !== 1'b1) begin failures++; $display("FAIL resume_next got=%b exp=1", bus.tick); end
  endtask

  task automatic test_score_saturate();
    field_t snap;
    bit     timed_out;
    snap = '0;
    timed_out = 1'b0;
    reset6 = 1'b1;
    bus6.enable = 1'b0;
    bus6.bird_row = 4'(gap_of(0));
    step();
    reset6 = 1'b0;
    bus6.enable = 1'b1;
    for (int n = 1; n <= 34 && !timed_out; n++) begin
      int c;
      c = 0;
      do begin
        step();
        c++;
      end while (!bus6.tick && c < 8);
      if (!bus6.tick) begin
        checks++;
        failures++;
        $display("FAIL sat_tick_timeout got=no tick exp=tick %0d", n);
        timed_out = 1'b1;
      end else begin
        if (n == 33) snap = bus6.GrnPixels;
        if (n == 14) begin
          checks++; if (bus6.score !== 2'd1) begin failures++; $display("FAIL sat_score_t14 got=%0d exp=1", bus6.score); end
        end
        if (n == 18) begin
          checks++; if (bus6.score !== 2'd2) begin failures++; $display("FAIL sat_score_t18 got=%0d exp=2", bus6.score); end
        end
        if (n == 26) begin
          checks++; if (bus6.score !== 2'd3) begin failures++; $display("FAIL sat_score_t26 got=%0d exp=3", bus6.score); end
        end
        if (n == 34) begin
          checks++; if (bus6.score !== 2'd3) begin failures++; $display("FAIL sat_score_t34 got=%0d exp=3", bus6.score); end
          checks++; if (bus6.collide !== 1'b0) begin failures++; $display("FAIL sat_collide got=%b exp=0", bus6.collide); end
          checks++; if (bus6.GrnPixels === snap) begin failures++; $display("FAIL sat_scrolling got=%h exp=changed", bus6.GrnPixels); end
        end
        if (n >= 11 && ((n - 11) % 4) == 0) bus6.bird_row = 4'(gap_of((n - 11) / 4));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    reset6 = 1'b1;
    bus.enable = 1'b0;
    bus.bird_row = '0;
    bus6.enable = 1'b0;
    bus6.bird_row = '0;
    test_reset();
    test_scroll_score();
    test_collide();
    test_reset_after_collide();
    test_enable_hold();
    test_score_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_field_gen.md
Name: pipe_field_gen

Overview:
Parametrised successor to the original fixed 16x16 light generator.
Produces the scrolling pipe field for the LED matrix:
- spawns pipe columns with a pseudo-random gap at a configurable spacing;
- scrolls the field at a divided rate;
- detects bird/pipe collision and counts pipes passed.
Sits between the game controller (enable, bird_row) and the LED matrix driver (GrnPixels).

Parameters:
ROWS, 16, matrix rows
COLS, 16, matrix columns; column COLS-1 is the entry column, column 0 is the exit column
GAP, 4, gap height in rows; legal range 1..ROWS-1
TICK_DIV, 8, clk cycles per scroll step; must be >= 2
SPACING, 6, ticks between pipe spawns (one pipe column, then SPACING-1 empty columns)
BIRD_COL, 3, fixed bird column; legal range 1..COLS-1
LFSR_SEED, 10'h1A5, LFSR reset value; a seed of 0 is replaced by 1
SCORE_W, 8, score width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
enable  in  1  game running; when low all state holds
bird_row  in  $clog2(ROWS)  current bird row
GrnPixels  out  [ROWS-1:0][COLS-1:0]  pipe field, indexed [row][col], registered
tick  out  1  one-cycle scroll strobe, registered
collide  out  1  sticky collision flag, registered
score  out  SCORE_W  pipes passed, registered, saturating

Behaviour:
- Reset (synchronous, highest priority, takes effect mid-game on the next edge):
  - GrnPixels = 0, tick = 0, collide = 0, score = 0;
  - divider = 0, spacing counter sp = 0 (so the first tick spawns a pipe);
  - lfsr = LFSR_SEED.
- Overlap (combinational) = GrnPixels[bird_row][BIRD_COL].
- Divider:
  - Counts 0..TICK_DIV-1 only when enable && !collide && !overlap.
  - tick_next = 1 when the divider is at TICK_DIV-1 under the same condition; the divider then wraps to 0.
  - The tick output goes high the cycle after the divider reaches TICK_DIV-1.
- Scroll: applied on the same edge that registers tick = 1.
  - new[r][c] = old[r][c+1] for c < COLS-1.
  - new[r][COLS-1] = spawn column.
  - The old column 0 is discarded.
- Spawn column:
  - If sp == 0: every row set except rows g..g+GAP-1. sp then reloads to SPACING-1.
  - Otherwise: all zeros, and sp decrements.
- Gap position g, computed from lfsr before it advances:
  - v = lfsr[$clog2(ROWS)-1:0];
  - g = v if v <= ROWS-GAP, else v-(ROWS-GAP+1).
- LFSR:
  - 10-bit Fibonacci, polynomial x^10 + x^7 + 1, shifting left with feedback into bit 0.
  - Advances only on scroll edges.
- Score:
  - On a scroll edge, if old column BIRD_COL has any bit set, score += 1, saturating at 2^SCORE_W-1.
  - This edge is the one where the pipe passes the bird.
- Collision:
  - collide is set on the edge after overlap is seen (1-cycle latency) and is cleared only by reset.
  - Overlap combinationally suppresses the scroll in the same cycle, so a colliding pipe never scores.
  - A change of bird_row into a pipe while the field is static also sets collide.
- While collide = 1: GrnPixels, score, the divider, sp and lfsr freeze, and tick = 0.
- enable low: everything holds and tick = 0. Re-raising enable resumes the divider from its held value.

Decomposition:
- Package flappy_pkg holds:
  - default ROWS/COLS;
  - LFSR width and tap constants;
  - typedef col_t (ROWS-bit column vector);
  - a function gap_mask(g) returning the spawn column.
- One sub-module, gap_lfsr: 10-bit LFSR with inputs clk, reset, advance and output state, seeded by parameter.
- Divider, shifter, collision and score logic live in pipe_field_gen.

Test Plan:
Default for all scenarios: ROWS=16, COLS=16, GAP=4, TICK_DIV=2, SPACING=4, BIRD_COL=3, LFSR_SEED=10'h1A5.
1. Reset hold then enable=1 -> first tick in the 2nd enabled cycle; column 15 becomes 16'hFE1F (gap rows 5..8, g=5); all other columns 0; score=0, collide=0.
2. enable=1, bird_row=6, run 14 ticks -> first pipe reaches column 3 after tick 13; score becomes 1 on tick 14; pipes then appear every 4 ticks; collide stays 0.
3. bird_row=0, run -> one cycle after tick 13, collide=1; GrnPixels frozen with the pipe at column 3; score=0; no further ticks for 20 cycles.
4. Toggle enable low for 10 cycles mid-run -> no tick and GrnPixels unchanged; on re-enable, tick spacing resumes with the divider value held.
5. Assert reset after collide=1 -> next cycle everything is zero, collide=0, lfsr=seed; scenario 1 sequence repeats exactly.
6. SCORE_W=2, bird_row kept in each gap via a bench model -> score saturates at 3; GrnPixels keeps scrolling.
